// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader: FSM state
// encoding, default frame header and checksum arithmetic.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Running modulo-256 checksum accumulation.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // A length byte of zero encodes a full 256-word frame.
  function automatic logic [8:0] frame_words(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes 16-bit words into instruction
// memory and releases the CPU only after the frame checksum verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [8:0]  words_loaded
);

  localparam logic [15:0] ADDR_MASK = 16'((32'd1 << ADDR_WIDTH) - 32'd1);

  state_e      state_r;
  logic [7:0]  len_r;
  logic [8:0]  word_cnt_r;
  logic [7:0]  csum_r;
  logic [7:0]  hi_r;
  logic        take_s;
  logic [15:0] word_idx_s;

  // Byte acceptance: only while receiving a frame, and never during restart.
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      ST_IDLE, ST_LEN, ST_HI, ST_LO, ST_CSUM: in_ready = ~restart;
      default:                                in_ready = 1'b0;
    endcase
  end

  assign take_s     = in_valid & in_ready;
  assign word_idx_s = {7'd0, word_cnt_r} & ADDR_MASK;

  // Frame FSM with checksum accumulator and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      len_r        <= 8'd0;
      word_cnt_r   <= 9'd0;
      csum_r       <= 8'd0;
      hi_r         <= 8'd0;
      imem_we      <= 1'b0;
      imem_addr    <= 16'd0;
      imem_wdata   <= 16'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 9'd0;
    end else if (restart) begin
      state_r      <= ST_IDLE;
      len_r        <= 8'd0;
      word_cnt_r   <= 9'd0;
      csum_r       <= 8'd0;
      imem_we      <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 9'd0;
    end else begin
      imem_we <= 1'b0;
      if (take_s) begin
        case (state_r)
          ST_IDLE: begin
            if (in_byte == HEADER) begin
              state_r      <= ST_LEN;
              len_r        <= 8'd0;
              word_cnt_r   <= 9'd0;
              csum_r       <= 8'd0;
              words_loaded <= 9'd0;
            end
          end
          ST_LEN: begin
            len_r   <= in_byte;
            csum_r  <= in_byte;
            state_r <= ST_HI;
          end
          ST_HI: begin
            hi_r    <= in_byte;
            csum_r  <= csum_add(csum_r, in_byte);
            state_r <= ST_LO;
          end
          ST_LO: begin
            csum_r       <= csum_add(csum_r, in_byte);
            imem_we      <= 1'b1;
            imem_addr    <= word_idx_s;
            imem_wdata   <= {hi_r, in_byte};
            words_loaded <= words_loaded + 9'd1;
            word_cnt_r   <= word_cnt_r + 9'd1;
            state_r      <= ((word_cnt_r + 9'd1) == frame_words(len_r)) ? ST_CSUM : ST_HI;
          end
          ST_CSUM: begin
            if (csum_add(csum_r, in_byte) == 8'd0) begin
              state_r  <= ST_DONE;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state_r  <= ST_ERR;
              error    <= 1'b1;
            end
          end
          default: state_r <= state_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        restart;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] wq_addr[$];
  logic [15:0] wq_data[$];

  imem_loader #(.ADDR_WIDTH(8), .HEADER(8'hA5)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wq_addr.push_back(imem_addr);
      wq_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  // Good frame A5 02 12 34 AB CD 40, with optional gaps between bytes.
  task automatic run_good(input int gap);
    wq_addr.delete();
    wq_data.delete();
    send(8'hA5, gap);
    send(8'h02, gap);
    send(8'h12, gap);
    send(8'h34, gap);
    check("w0_we",    {31'd0, imem_we}, 32'd1);
    check("w0_addr",  {16'd0, imem_addr}, 32'h0000);
    check("w0_data",  {16'd0, imem_wdata}, 32'h1234);
    check("w0_count", {23'd0, words_loaded}, 32'd1);
    send(8'hAB, gap);
    check("w0_pulse", {31'd0, imem_we}, 32'd0);
    send(8'hCD, gap);
    check("w1_addr",  {16'd0, imem_addr}, 32'h0001);
    check("w1_data",  {16'd0, imem_wdata}, 32'hABCD);
    check("hold_pre", {31'd0, cpu_hold}, 32'd1);
    send(8'h40, gap);
    check("good_done",  {31'd0, done}, 32'd1);
    check("good_hold",  {31'd0, cpu_hold}, 32'd0);
    check("good_err",   {31'd0, error}, 32'd0);
    check("good_words", {23'd0, words_loaded}, 32'd2);
    check("good_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("good_nwr", 32'(wq_addr.size()), 32'd2);
    check("good_a0",  {16'd0, wq_addr[0]}, 32'h0000);
    check("good_d0",  {16'd0, wq_data[0]}, 32'h1234);
    check("good_a1",  {16'd0, wq_addr[1]}, 32'h0001);
    check("good_d1",  {16'd0, wq_data[1]}, 32'hABCD);
  endtask

  initial begin
    reset = 1'b1;
    restart = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_hold",  {31'd0, cpu_hold}, 32'd1);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_err",   {31'd0, error}, 32'd0);
    check("rst_we",    {31'd0, imem_we}, 32'd0);
    check("rst_addr",  {16'd0, imem_addr}, 32'd0);
    check("rst_wdata", {16'd0, imem_wdata}, 32'd0);
    check("rst_words", {23'd0, words_loaded}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    // Good frame back to back.
    run_good(0);

    // Bad checksum.
    do_restart();
    wq_addr.delete();
    wq_data.delete();
    send(8'hA5, 0); send(8'h02, 0); send(8'h12, 0); send(8'h34, 0);
    send(8'hAB, 0); send(8'hCD, 0); send(8'h41, 0);
    check("bad_err",   {31'd0, error}, 32'd1);
    check("bad_done",  {31'd0, done}, 32'd0);
    check("bad_hold",  {31'd0, cpu_hold}, 32'd1);
    check("bad_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check("bad_nwr",   32'(wq_addr.size()), 32'd2);
    check("bad_d1",    {16'd0, wq_data[1]}, 32'hABCD);

    // Leading garbage, then gapped good frame.
    do_restart();
    check("rs_err", {31'd0, error}, 32'd0);
    send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
    check("garb_ready", {31'd0, in_ready}, 32'd1);
    check("garb_words", {23'd0, words_loaded}, 32'd0);
    run_good(3);

    // Maximum length: 256 words, value = index, checksum 0x80.
    do_restart();
    wq_addr.delete();
    wq_data.delete();
    send(8'hA5, 0);
    send(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      send(8'h00, 0);
      send(8'(i), 0);
    end
    send(8'h80, 0);
    check("max_done",  {31'd0, done}, 32'd1);
    check("max_words", {23'd0, words_loaded}, 32'd256);
    check("max_addr",  {16'd0, imem_addr}, 32'h00FF);
    check("max_wdata", {16'd0, imem_wdata}, 32'h00FF);
    repeat (2) @(negedge clk);
    check("max_nwr",   32'(wq_addr.size()), 32'd256);
    check("max_a128",  {16'd0, wq_addr[128]}, 32'h0080);
    check("max_d255",  {16'd0, wq_data[255]}, 32'h00FF);

    // Restart mid-frame with a byte offered in the restart cycle.
    do_restart();
    send(8'hA5, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0);
    check("pre_rs_words", {23'd0, words_loaded}, 32'd1);
    @(negedge clk);
    restart = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'hA5;
    #1;
    check("rs_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    restart = 1'b0;
    in_valid = 1'b0;
    check("rs_words", {23'd0, words_loaded}, 32'd0);
    check("rs_hold",  {31'd0, cpu_hold}, 32'd1);
    check("rs_we",    {31'd0, imem_we}, 32'd0);
    run_good(0);

    // Async reset while done=1: no clock edge between assert and check.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("ar_done",  {31'd0, done}, 32'd0);
    check("ar_hold",  {31'd0, cpu_hold}, 32'd1);
    check("ar_words", {23'd0, words_loaded}, 32'd0);
    check("ar_addr",  {16'd0, imem_addr}, 32'd0);
    check("ar_wdata", {16'd0, imem_wdata}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Async reset while in HI with a write just issued.
    send(8'hA5, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0);
    check("hi_wdata_pre", {16'd0, imem_wdata}, 32'h1122);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("arhi_wdata", {16'd0, imem_wdata}, 32'd0);
    check("arhi_we",    {31'd0, imem_we}, 32'd0);
    check("arhi_words", {23'd0, words_loaded}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arhi_ready", {31'd0, in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
